// File: rtl/network_div_pkg.sv
// Shared constants and FSM state type for the sequential signed divider.
package network_div_pkg;
  localparam int DIV_DIVIDEND_W = 26;
  localparam int DIV_DIVISOR_W  = 10;
  localparam int DIV_QUOT_W     = 16;
  localparam int DIV_ITER       = 26;
  localparam int Q_MAX          = 32767;
  localparam int Q_MIN          = -32768;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} div_state_e;
endpackage

// File: rtl/network_div_sat_16.sv
// Applies the quotient sign to a 26-bit magnitude and clamps to the signed 16-bit range.
module network_div_sat_16
  import network_div_pkg::*;
(
  input  logic [DIV_DIVIDEND_W-1:0]    i_mag,
  input  logic                         i_neg,
  output logic signed [DIV_QUOT_W-1:0] o_dout,
  output logic                         o_ovf
);
  always_comb begin
    o_dout = '0;
    o_ovf  = 1'b0;
    if (!i_neg) begin
      if (i_mag > DIV_DIVIDEND_W'(Q_MAX)) begin
        o_dout = DIV_QUOT_W'(Q_MAX);
        o_ovf  = 1'b1;
      end else begin
        o_dout = i_mag[DIV_QUOT_W-1:0];
      end
    end else begin
      // Negative side reaches one further: a magnitude of 32768 is exactly Q_MIN.
      if (i_mag > DIV_DIVIDEND_W'(-Q_MIN)) begin
        o_dout = DIV_QUOT_W'(Q_MIN);
        o_ovf  = 1'b1;
      end else begin
        o_dout = ~i_mag[DIV_QUOT_W-1:0] + 16'd1;
      end
    end
  end
endmodule

// File: rtl/network_div_seq_26s_10s_16.sv
// Radix-2 restoring signed divider, 26s / 10s -> saturated 16s quotient plus exact remainder.
module network_div_seq_26s_10s_16
  import network_div_pkg::*;
#(
  parameter int ID         = 1,
  parameter int NUM_STAGE  = 28,
  parameter int din0_WIDTH = 26,
  parameter int din1_WIDTH = 10,
  parameter int dout_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ce,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [din0_WIDTH-1:0] din0,
  input  logic signed [din1_WIDTH-1:0] din1,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [dout_WIDTH-1:0] dout,
  output logic signed [din1_WIDTH-1:0] rem,
  output logic                         ovf,
  output logic                         div0
);
  if (ID < 0 || NUM_STAGE != DIV_ITER + 2 || din0_WIDTH != DIV_DIVIDEND_W ||
      din1_WIDTH != DIV_DIVISOR_W || dout_WIDTH != DIV_QUOT_W) begin : g_cfg_err
    $error("network_div_seq_26s_10s_16: unsupported parameter set");
  end

  div_state_e                    r_state, w_state_nxt;
  logic [4:0]                    r_cnt;
  logic [din0_WIDTH-1:0]         r_q;
  logic [din1_WIDTH-1:0]         r_r;
  logic [din1_WIDTH:0]           r_d;
  logic                          r_s0, r_s1, r_z;
  logic                          r_out_valid, r_ovf, r_div0;
  logic signed [dout_WIDTH-1:0]  r_dout;
  logic signed [din1_WIDTH-1:0]  r_rem;

  logic [din0_WIDTH-1:0]         w_d0u, w_mag0;
  logic [din1_WIDTH:0]           w_d1x, w_mag1, w_trial, w_diff;
  logic                          w_ge;
  logic [din1_WIDTH-1:0]         w_rem_s;
  logic signed [dout_WIDTH-1:0]  w_sat_dout;
  logic                          w_sat_ovf;

  assign w_d0u  = din0;
  assign w_mag0 = w_d0u[din0_WIDTH-1] ? (~w_d0u + 26'd1) : w_d0u;
  // One extra bit so |-512| = 512 is representable.
  assign w_d1x  = {din1[din1_WIDTH-1], din1};
  assign w_mag1 = din1[din1_WIDTH-1] ? (~w_d1x + 11'd1) : w_d1x;

  assign w_trial = {r_r, r_q[din0_WIDTH-1]};
  assign w_diff  = w_trial - r_d;
  assign w_ge    = (w_trial >= r_d);
  assign w_rem_s = r_z ? '0 : (r_s0 ? (~r_r + 10'd1) : r_r);

  network_div_sat_16 u_sat (
    .i_mag  (r_q),
    .i_neg  (r_z ? r_s0 : (r_s0 ^ r_s1)),
    .o_dout (w_sat_dout),
    .o_ovf  (w_sat_ovf)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_state_nxt = CALC;
      CALC:    if (r_cnt == 5'd0) w_state_nxt = FIX;
      FIX:     w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Control and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_dout      <= '0;
      r_rem       <= '0;
      r_ovf       <= 1'b0;
      r_div0      <= 1'b0;
    end else if (ce) begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: if (in_valid) r_cnt <= 5'(DIV_ITER - 1);
        CALC: r_cnt <= r_cnt - 5'd1;
        FIX: begin
          r_out_valid <= 1'b1;
          r_dout      <= w_sat_dout;
          r_rem       <= w_rem_s;
          r_ovf       <= w_sat_ovf | r_z;
          r_div0      <= r_z;
        end
        DONE: if (out_ready) begin
          r_out_valid <= 1'b0;
          r_ovf       <= 1'b0;
          r_div0      <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Operand load and shift/subtract datapath
  always_ff @(posedge clk) begin
    if (ce) begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_q  <= w_mag0;
          r_r  <= '0;
          r_d  <= w_mag1;
          r_s0 <= din0[din0_WIDTH-1];
          r_s1 <= din1[din1_WIDTH-1];
          r_z  <= (din1 == '0);
        end
        CALC: begin
          r_q <= {r_q[din0_WIDTH-2:0], w_ge};
          r_r <= w_ge ? 10'(w_diff) : 10'(w_trial);
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE) && reset;
  assign out_valid = r_out_valid;
  assign dout      = r_dout;
  assign rem       = r_rem;
  assign ovf       = r_ovf;
  assign div0      = r_div0;
endmodule

// File: tb/tb_network_div_seq_26s_10s_16.sv
// Directed bench for the sequential signed divider: reset, signs, saturation, div-by-zero, stalls.
module tb_network_div_seq_26s_10s_16;
  logic clk = 1'b0, reset = 1'b1, ce = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic signed [25:0] din0 = '0;
  logic signed [9:0]  din1 = '0;
  logic               in_ready, out_valid, ovf, div0;
  logic signed [15:0] dout;
  logic signed [9:0]  rem;
  int n_cmp = 0, n_err = 0;
  int lat, busy_bad, seen;

  network_div_seq_26s_10s_16 dut (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_ready(in_ready),
    .din0(din0), .din1(din1), .out_valid(out_valid), .out_ready(out_ready),
    .dout(dout), .rem(rem), .ovf(ovf), .div0(div0)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed running expected done");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Launches one division; counts edges from the accept edge (inclusive) to out_valid.
  task automatic do_op(input logic signed [25:0] a, input logic signed [9:0] b,
                       input int ce_at, input int ce_len, output int l, output int bb);
    bb = 0;
    @(negedge clk);
    din0 = a; din1 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    l = 1;
    while (out_valid !== 1'b1 && l < 120) begin
      if (l == ce_at) ce = 1'b0;
      if (l == ce_at + ce_len) ce = 1'b1;
      if (l == 5) begin din0 = 26'sd7; din1 = 10'sd1; in_valid = 1'b1; end
      if (l == 7) in_valid = 1'b0;
      if (in_ready !== 1'b0) bb++;
      @(posedge clk); #1;
      l++;
    end
    ce = 1'b1;
  endtask

  task automatic finish_op();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("post_out_valid", out_valid, 0);
    chk("post_ovf", ovf, 0);
    chk("post_div0", div0, 0);
    chk("post_in_ready", in_ready, 1);
  endtask

  initial begin
    #2 reset = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_dout", dout, 0);
    chk("rst_rem", rem, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_div0", div0, 0);
    @(negedge clk);
    reset = 1'b1;
    #1 chk("rel_in_ready", in_ready, 1);

    do_op(26'sd1000, 10'sd7, 0, 0, lat, busy_bad);
    chk("p7_latency", lat, 28);
    chk("p7_dout", dout, 142);
    chk("p7_rem", rem, 6);
    chk("p7_ovf", ovf, 0);
    chk("p7_div0", div0, 0);
    chk("p7_busy_in_ready", busy_bad, 0);
    finish_op();

    do_op(-26'sd1000, 10'sd7, 0, 0, lat, busy_bad);
    chk("n7_dout", dout, -142);
    chk("n7_rem", rem, -6);
    finish_op();

    do_op(26'sd1000, -10'sd7, 0, 0, lat, busy_bad);
    chk("pn7_dout", dout, -142);
    chk("pn7_rem", rem, 6);
    chk("pn7_ovf", ovf, 0);
    finish_op();

    do_op(26'sd16777216, 10'sd1, 0, 0, lat, busy_bad);
    chk("bigpos_dout", dout, 32767);
    chk("bigpos_ovf", ovf, 1);
    chk("bigpos_rem", rem, 0);
    finish_op();

    do_op(-26'sd16777216, 10'sd1, 0, 0, lat, busy_bad);
    chk("bigneg_dout", dout, -32768);
    chk("bigneg_ovf", ovf, 1);
    finish_op();

    do_op(-26'sd33554432, -10'sd1, 0, 0, lat, busy_bad);
    chk("minneg1_dout", dout, 32767);
    chk("minneg1_ovf", ovf, 1);
    chk("minneg1_rem", rem, 0);
    finish_op();

    do_op(26'sd500, 10'sd0, 0, 0, lat, busy_bad);
    chk("z_pos_latency", lat, 28);
    chk("z_pos_dout", dout, 32767);
    chk("z_pos_div0", div0, 1);
    chk("z_pos_ovf", ovf, 1);
    chk("z_pos_rem", rem, 0);
    finish_op();

    do_op(-26'sd500, 10'sd0, 0, 0, lat, busy_bad);
    chk("z_neg_dout", dout, -32768);
    chk("z_neg_div0", div0, 1);
    finish_op();

    do_op(26'sd100000, -10'sd512, 0, 0, lat, busy_bad);
    chk("m512_dout", dout, -195);
    chk("m512_rem", rem, 160);
    chk("m512_ovf", ovf, 0);
    finish_op();

    do_op(26'sd1000, 10'sd7, 10, 4, lat, busy_bad);
    chk("ce_latency", lat, 32);
    chk("ce_busy_in_ready", busy_bad, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_out_valid", out_valid, 1);
      chk("hold_dout", dout, 142);
      chk("hold_rem", rem, 6);
      chk("hold_in_ready", in_ready, 0);
    end
    finish_op();

    @(negedge clk);
    din0 = 26'sd1000; din1 = 10'sd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (15) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_out_valid", out_valid, 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrel_in_ready", in_ready, 1);
    chk("midrel_out_valid", out_valid, 0);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) seen++;
    end
    chk("midrel_no_result", seen, 0);

    do_op(26'sd100, 10'sd3, 0, 0, lat, busy_bad);
    chk("d3_latency", lat, 28);
    chk("d3_dout", dout, 33);
    chk("d3_rem", rem, 1);
    finish_op();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
